// File: rtl/iob_eth_fifo_regs.sv
// Ethernet host register block on the IOb native bus: IRQ mask, interface control,
// 16-byte RX/TX FIFOs and the TX burst sequencer feeding the MAC byte stream.
module iob_eth_fifo_regs #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic [31:0]         if_ctrl_o,
  output logic                irq_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;
  tx_state_t tx_state, tx_state_nxt;

  logic [7:0]         tx_mem [DEPTH];
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]      tx_cnt, rx_cnt;
  logic [1:0]         int_mask;
  logic               tx_done, tx_ovf, rx_ovf, tx_busy, tx_done_set;
  logic               vld_p1;
  logic [DATA_W-1:0]  rdata_p0, rdata_p1;

  // Stage p0: request decode and FIFO push/pop qualification
  logic       mapped, rd_req, wr_req, stat_rd, tx_start;
  logic       rx_full, rx_pop, rx_push, tx_full, tx_pop, tx_wr, tx_push;
  logic [2:0] sel;

  assign mapped   = (address[ADDR_W-1:3] == '0);
  assign sel      = address[2:0];
  assign rd_req   = valid && mapped && (wstrb == '0);
  assign wr_req   = valid && mapped && (wstrb != '0);
  assign stat_rd  = rd_req && (sel == 3'd4);
  assign tx_start = wr_req && (sel == 3'd4) && (tx_state == TX_IDLE);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_pop   = rd_req && (sel == 3'd2) && (rx_cnt != '0);
  assign rx_push  = rx_valid_i && (!rx_full || rx_pop);
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_pop   = tx_valid_o && tx_ready_i;
  assign tx_wr    = wr_req && (sel == 3'd3) && wstrb[0];
  assign tx_push  = tx_wr && (!tx_full || tx_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  // SEND stays put if a byte lands in an empty FIFO, so it joins the current burst
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_state_nxt = TX_SEND;
      TX_SEND: if ((tx_cnt == '0) && !tx_push) tx_state_nxt = TX_DONE;
      TX_DONE: tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o  = (tx_state == TX_SEND) && (tx_cnt != '0);
    tx_busy     = (tx_state != TX_IDLE);
    tx_done_set = (tx_state == TX_DONE);
  end

  assign tx_data_o = tx_valid_o ? tx_mem[tx_rd_ptr] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + FIFO_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + FIFO_AW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + FIFO_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + FIFO_AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky flags: a set in the same cycle as a status-read clear wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_mask  <= '0;
      if_ctrl_o <= '0;
      tx_done   <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (wr_req && (sel == 3'd0) && wstrb[0]) int_mask <= wdata[1:0];
      if (wr_req && (sel == 3'd1)) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) if_ctrl_o[8*b +: 8] <= wdata[8*b +: 8];
      end
      if (stat_rd) begin
        tx_done <= 1'b0;
        tx_ovf  <= 1'b0;
        rx_ovf  <= 1'b0;
      end
      if (tx_done_set)              tx_done <= 1'b1;
      if (tx_wr && !tx_push)        tx_ovf  <= 1'b1;
      if (rx_valid_i && !rx_push)   rx_ovf  <= 1'b1;
    end
  end

  always_comb begin
    rdata_p0 = '0;
    if (rd_req) begin
      case (sel)
        3'd0:    rdata_p0 = DATA_W'(int_mask);
        3'd1:    rdata_p0 = if_ctrl_o;
        3'd2:    rdata_p0 = (rx_cnt != '0) ? DATA_W'(rx_mem[rx_rd_ptr])
                                           : {1'b1, {(DATA_W-1){1'b0}}};
        3'd4:    rdata_p0 = DATA_W'({5'(rx_cnt), 5'(tx_cnt), 2'b00,
                                     tx_busy, tx_done, tx_ovf, rx_ovf});
        default: rdata_p0 = '0;
      endcase
    end
  end

  // Stage p1: registered response, rdata held until the next request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= valid;
      if (valid) rdata_p1 <= rdata_p0;
    end
  end

  assign ready = vld_p1;
  assign rdata = rdata_p1;
  assign irq_o = |(int_mask & {tx_done, (rx_cnt != '0)});

endmodule

// File: tb/tb_iob_eth_fifo_regs.sv
// Bench for iob_eth_fifo_regs: directed scenarios plus randomized register traffic
// checked against a queue-based model of the register map and FIFOs.
module tb_iob_eth_fifo_regs;
  logic        clk_i = 1'b0;
  logic        rst_i, valid;
  logic [15:0] address;
  logic [31:0] wdata, rdata, if_ctrl_o;
  logic [3:0]  wstrb;
  logic        ready, tx_valid_o, tx_ready_i, rx_valid_i, irq_o;
  logic [7:0]  tx_data_o, rx_data_i;

  iob_eth_fifo_regs #(.ADDR_W(16), .DATA_W(32), .FIFO_AW(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .if_ctrl_o(if_ctrl_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  rxq[$], txq[$], got_tx[$];
  int          got_cyc[$];
  logic [1:0]  m_mask;
  logic [31:0] m_ifctrl;
  bit          m_done, m_tovf, m_rovf, model_on;
  int          n_chk = 0, n_err = 0, cyc = 0;
  bit          rv, rrx;
  logic [15:0] ra;
  logic [3:0]  rws;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record each byte whose handshake completes at the coming posedge
  always @(negedge clk_i)
    if (!rst_i && tx_valid_o && tx_ready_i) begin
      got_tx.push_back(tx_data_o);
      got_cyc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    rxq.delete(); txq.delete(); got_tx.delete(); got_cyc.delete();
    m_mask = '0; m_ifctrl = '0; m_done = 0; m_tovf = 0; m_rovf = 0; model_on = 1;
  endtask

  // One clock of bus/RX stimulus; the model predicts the response and the new state
  task automatic cycle(input bit v, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit rxv, input logic [7:0] rxd);
    logic [31:0] exp;
    bit mapped, rd, wr, popped, stat, exp_irq;
    valid = v; address = a; wdata = wd; wstrb = ws; rx_valid_i = rxv; rx_data_i = rxd;
    mapped = (a[15:3] == 13'd0);
    rd = v && mapped && (ws == 4'h0);
    wr = v && mapped && (ws != 4'h0);
    exp = 32'h0; popped = 0; stat = 0;
    if (rd) begin
      case (a[2:0])
        3'd0: exp = {30'b0, m_mask};
        3'd1: exp = m_ifctrl;
        3'd2: if (rxq.size() > 0) begin exp = {24'b0, rxq[0]}; popped = 1; end
              else exp = 32'h8000_0000;
        3'd4: begin
          exp = {16'b0, 5'(rxq.size()), 5'(txq.size()), 2'b0, 1'b0, m_done, m_tovf, m_rovf};
          stat = 1;
        end
        default: exp = 32'h0;
      endcase
    end
    @(posedge clk_i);
    #1;
    valid = 1'b0; rx_valid_i = 1'b0;
    if (popped) void'(rxq.pop_front());
    if (stat) begin m_done = 0; m_tovf = 0; m_rovf = 0; end
    if (wr) begin
      case (a[2:0])
        3'd0: if (ws[0]) m_mask = wd[1:0];
        3'd1: for (int b = 0; b < 4; b++) if (ws[b]) m_ifctrl[8*b +: 8] = wd[8*b +: 8];
        3'd3: if (ws[0]) begin
                if (txq.size() < 16) txq.push_back(wd[7:0]);
                else m_tovf = 1;
              end
        default: ;
      endcase
    end
    if (rxv) begin
      if (rxq.size() < 16) rxq.push_back(rxd);
      else m_rovf = 1;
    end
    chk("ready", 32'(ready), 32'(v));
    if (model_on) begin
      if (v && ws == 4'h0) chk("rdata", rdata, exp);
      exp_irq = (m_mask[0] && rxq.size() != 0) || (m_mask[1] && m_done);
      chk("irq", 32'(irq_o), 32'(exp_irq));
      chk("if_ctrl_o", if_ctrl_o, m_ifctrl);
    end
  endtask

  task automatic wait_tx(input int n, input int budget, input bit rnd);
    int k;
    k = 0;
    while (got_tx.size() < n && k < budget) begin
      if (rnd) tx_ready_i = 1'($urandom_range(0, 1));
      cycle(0, 16'd0, 32'd0, 4'h0, 0, 8'd0);
      k++;
    end
    chk("tx_count", 32'(got_tx.size()), 32'(n));
  endtask

  task automatic start_tx(input bit rdy);
    tx_ready_i = rdy;
    cycle(1, 16'd4, 32'd0, 4'hF, 0, 8'd0);
    model_on = 0;
  endtask

  // Let the sequencer pass DONE, then compare the stream with the queued bytes
  task automatic finish_burst(input string tag);
    int n;
    n = got_tx.size();
    tx_ready_i = 1'b1;
    repeat (4) cycle(0, 16'd0, 32'd0, 4'h0, 0, 8'd0);
    chk({tag, "_extra"}, 32'(got_tx.size()), 32'(n));
    for (int i = 0; i < txq.size(); i++)
      chk(tag, (i < got_tx.size()) ? 32'(got_tx[i]) : 32'hFFFF_FFFF, 32'(txq[i]));
    txq.delete(); got_tx.delete(); got_cyc.delete();
    m_done = 1; model_on = 1; tx_ready_i = 1'b0;
  endtask

  initial begin
    // Reset state and IF_CTRL byte strobes
    do_reset();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_if_ctrl", if_ctrl_o, 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    cycle(1, 16'd1, 32'd0, 4'h0, 0, 8'd0);
    chk("ifctrl_rst_rd", rdata, 32'd0);
    cycle(1, 16'd1, 32'hA5A5_0F0F, 4'b0101, 0, 8'd0);
    cycle(1, 16'd1, 32'd0, 4'h0, 0, 8'd0);
    chk("ifctrl_rd", rdata, 32'h00A5_000F);
    chk("ifctrl_out", if_ctrl_o, 32'h00A5_000F);

    // Three-byte burst on consecutive cycles, then tx_done reported once
    cycle(1, 16'd3, 32'h11, 4'h1, 0, 8'd0);
    cycle(1, 16'd3, 32'h22, 4'h1, 0, 8'd0);
    cycle(1, 16'd3, 32'h33, 4'h1, 0, 8'd0);
    start_tx(1'b1);
    wait_tx(3, 20, 0);
    chk("tx_b0", 32'(got_tx[0]), 32'h11);
    chk("tx_b1", 32'(got_tx[1]), 32'h22);
    chk("tx_b2", 32'(got_tx[2]), 32'h33);
    chk("tx_consec", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
    finish_burst("tx3");
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);
    chk("stat_done", rdata, 32'h0000_0004);
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);
    chk("stat_clear", rdata, 32'h0000_0000);

    // TX overflow: 17th byte dropped and never emitted
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 16'd3, 32'(8'h40 + i), 4'h1, 0, 8'd0);
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);
    chk("stat_tx_full", rdata, 32'h0000_0402);
    start_tx(1'b1);
    wait_tx(16, 60, 0);
    finish_burst("tx16");

    // RX FIFO reads and the RX interrupt
    do_reset();
    cycle(0, 16'd0, 32'd0, 4'h0, 1, 8'hDE);
    cycle(0, 16'd0, 32'd0, 4'h0, 1, 8'hAD);
    cycle(1, 16'd0, 32'd1, 4'h1, 0, 8'd0);
    chk("irq_set", 32'(irq_o), 32'd1);
    cycle(1, 16'd2, 32'd0, 4'h0, 0, 8'd0);
    chk("rx_rd0", rdata, 32'h0000_00DE);
    cycle(1, 16'd2, 32'd0, 4'h0, 0, 8'd0);
    chk("rx_rd1", rdata, 32'h0000_00AD);
    chk("irq_clr", 32'(irq_o), 32'd0);
    cycle(1, 16'd2, 32'd0, 4'h0, 0, 8'd0);
    chk("rx_empty", rdata, 32'h8000_0000);

    // Full RX FIFO: simultaneous push and pop, no overflow
    do_reset();
    for (int i = 0; i < 16; i++) cycle(0, 16'd0, 32'd0, 4'h0, 1, 8'(i * 7));
    cycle(1, 16'd2, 32'd0, 4'h0, 1, 8'h77);
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);
    chk("rx_full_pp", rdata, 32'h0000_8000);

    // Reset in the middle of a burst; the in-flight request gets no ready
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 16'd3, 32'(8'hC0 + i), 4'h1, 0, 8'd0);
    start_tx(1'b1);
    wait_tx(3, 20, 0);
    rst_i = 1'b1; valid = 1'b1; address = 16'd1; wstrb = 4'h0;
    @(posedge clk_i);
    #1;
    chk("rst_mid_txv", 32'(tx_valid_o), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    valid = 1'b0; rst_i = 1'b0;
    rxq.delete(); txq.delete(); got_tx.delete(); got_cyc.delete();
    m_mask = '0; m_ifctrl = '0; m_done = 0; m_tovf = 0; m_rovf = 0; model_on = 1;
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);
    chk("rst_mid_stat", rdata, 32'h0000_0000);

    // Randomized register and RX traffic with the sequencer idle
    do_reset();
    tx_ready_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      ra  = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra[9] = 1'b1;
      rws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (ra == 16'd4) rws = 4'h0;
      rrx = ($urandom_range(0, 2) == 0);
      cycle(rv, ra, $urandom, rws, rrx, 8'($urandom));
    end
    start_tx(1'b1);
    wait_tx(txq.size(), 300, 1);
    finish_burst("tx_rand");
    cycle(1, 16'd4, 32'd0, 4'h0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
